// File: rtl/hub75_capture_if.sv
// HUB75 panel bus bundle: the controller drives it as master, the capture
// block observes it as slave.
interface hub75_capture_if #(
    parameter int ROW_BITS = 4
);
    logic                m_clk;
    logic                m_oe;
    logic                m_latch;
    logic [ROW_BITS-1:0] m_row_sel;
    logic [2:0]          m_color1;
    logic [2:0]          m_color2;

    modport master (output m_clk, m_oe, m_latch, m_row_sel, m_color1, m_color2);
    modport slave  (input  m_clk, m_oe, m_latch, m_row_sel, m_color1, m_color2);
endinterface

// File: rtl/hub75_capture.sv
// HUB75 panel-side receiver: rebuilds each latched line and drains it into a
// {row, col} capture RAM. Optional OE low-time meter under HUB75_OE_MEASURE_EN.
//
// state   | meaning
// S_IDLE  | waiting for a latch edge to commit the shifted line
// S_DRAIN | writing hold_buf to the capture RAM, one column per cycle
module hub75_capture #(
    parameter int MATRIX_COLS = 64,
    parameter int ROW_BITS    = 4,
    parameter int COL_BITS    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         i_clk,
    input  logic                         rst_n,
    hub75_capture_if.slave               hub,
    input  logic                         i_clr_err,
    output logic                         o_wr_en,
    output logic [ROW_BITS+COL_BITS-1:0] o_wr_addr,
    output logic [5:0]                   o_wr_data,
    output logic                         o_line_done,
    output logic                         o_busy,
    output logic                         o_len_err,
    output logic                         o_overrun,
`ifdef HUB75_OE_MEASURE_EN
    output logic [15:0]                  o_oe_width,
    output logic                         o_oe_valid,
`endif
    output logic [15:0]                  o_line_cnt
);

    localparam int                  SW      = ROW_BITS + 9;
    localparam logic [COL_BITS:0]   COLS_W  = (COL_BITS+1)'(MATRIX_COLS);
    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(MATRIX_COLS - 1);

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t state_q, state_d;
    logic [COL_BITS-1:0] drain_col_q, drain_col_d;

    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_d [SYNC_STAGES];
    logic [2:0]    edge_prev_q, edge_prev_d;
    logic [SW-1:0] s_last;

    logic [5:0]          s_pix;
    logic [ROW_BITS-1:0] s_row;
    logic                s_mclk, s_latch, s_oe;
    logic                clk_rise, latch_rise, oe_rise, commit, len_bad;

    logic [COL_BITS:0]   col_cnt_q, col_cnt_d;
    logic                ovl_q, ovl_d;
    logic [5:0]          shift_buf_q [MATRIX_COLS];
    logic [5:0]          shift_buf_d [MATRIX_COLS];
    logic [5:0]          hold_buf_q  [MATRIX_COLS];
    logic [5:0]          hold_buf_d  [MATRIX_COLS];
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [15:0]         line_cnt_q, line_cnt_d;
    logic                len_err_q, len_err_d;
    logic                overrun_q, overrun_d;

    logic                         wr_en_q, wr_en_d;
    logic [ROW_BITS+COL_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [5:0]                   wr_data_q, wr_data_d;
    logic                         line_done_q, line_done_d;
    logic                         busy_q, busy_d;

    // Sync bundle layout: {oe, latch, clk, row, color2, color1}
    always_comb begin
        sync_d[0] = {hub.m_oe, hub.m_latch, hub.m_clk, hub.m_row_sel, hub.m_color2, hub.m_color1};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        s_last      = sync_q[SYNC_STAGES-1];
        edge_prev_d = s_last[SW-1 -: 3];
    end

    assign s_pix      = s_last[5:0];
    assign s_row      = s_last[6 +: ROW_BITS];
    assign s_mclk     = s_last[ROW_BITS+6];
    assign s_latch    = s_last[ROW_BITS+7];
    assign s_oe       = s_last[ROW_BITS+8];
    assign clk_rise   = s_mclk  & ~edge_prev_q[0];
    assign latch_rise = s_latch & ~edge_prev_q[1];
    assign oe_rise    = s_oe    & ~edge_prev_q[2];
    assign commit     = latch_rise & (state_q == S_IDLE);
    assign len_bad    = (col_cnt_q != COLS_W) | ovl_q;

    // Latch clears the column first so a coincident shift edge lands in column 0.
    always_comb begin
        col_cnt_d   = col_cnt_q;
        ovl_d       = ovl_q;
        shift_buf_d = shift_buf_q;
        if (latch_rise) begin
            col_cnt_d = '0;
            ovl_d     = 1'b0;
        end
        if (clk_rise) begin
            if (col_cnt_d < COLS_W) begin
                shift_buf_d[col_cnt_d[COL_BITS-1:0]] = s_pix;
                col_cnt_d = col_cnt_d + 1'b1;
            end else begin
                ovl_d = 1'b1;
            end
        end
        hold_buf_d = commit ? shift_buf_q : hold_buf_q;
        row_d      = commit ? s_row : row_q;
        line_cnt_d = commit ? line_cnt_q + 1'b1 : line_cnt_q;
        len_err_d  = (latch_rise & len_bad) ? 1'b1 : (i_clr_err ? 1'b0 : len_err_q);
        overrun_d  = (latch_rise & (state_q == S_DRAIN)) ? 1'b1 : (i_clr_err ? 1'b0 : overrun_q);
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            edge_prev_q <= '0;
            col_cnt_q   <= '0;
            ovl_q       <= 1'b0;
            row_q       <= '0;
            line_cnt_q  <= '0;
            len_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            edge_prev_q <= edge_prev_d;
            col_cnt_q   <= col_cnt_d;
            ovl_q       <= ovl_d;
            row_q       <= row_d;
            line_cnt_q  <= line_cnt_d;
            len_err_q   <= len_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge i_clk) begin
        shift_buf_q <= shift_buf_d;
        hold_buf_q  <= hold_buf_d;
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            drain_col_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_col_q <= drain_col_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_col_d = '0;
        case (state_q)
            S_IDLE:  if (latch_rise) state_d = S_DRAIN;
            S_DRAIN: begin
                drain_col_d = drain_col_q + 1'b1;
                if (drain_col_q == COL_MAX) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en_d     = 1'b0;
        busy_d      = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        line_done_d = wr_en_q && (wr_addr_q[COL_BITS-1:0] == COL_MAX);
        if (state_q == S_DRAIN) begin
            wr_en_d   = 1'b1;
            busy_d    = 1'b1;
            wr_addr_d = {row_q, drain_col_q};
            wr_data_d = hold_buf_q[drain_col_q];
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            line_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            line_done_q <= line_done_d;
            busy_q      <= busy_d;
        end
    end

    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_line_done = line_done_q;
    assign o_busy      = busy_q;
    assign o_len_err   = len_err_q;
    assign o_overrun   = overrun_q;
    assign o_line_cnt  = line_cnt_q;

`ifdef HUB75_OE_MEASURE_EN
    logic [15:0] oe_cnt_q, oe_cnt_d;
    logic [15:0] oe_width_q, oe_width_d;
    logic        oe_valid_q, oe_valid_d;
    logic        oe_arm_q, oe_arm_d;

    // Armed by a commit; reports once, on the next latch edge or the first OE release.
    always_comb begin
        oe_cnt_d   = oe_cnt_q;
        oe_width_d = oe_width_q;
        oe_valid_d = 1'b0;
        oe_arm_d   = oe_arm_q;
        if (oe_arm_q && (latch_rise || (oe_rise && oe_cnt_q != 16'd0))) begin
            oe_width_d = oe_cnt_q;
            oe_valid_d = 1'b1;
            oe_arm_d   = 1'b0;
        end
        if (commit) begin
            oe_cnt_d = '0;
            oe_arm_d = 1'b1;
        end else if (!s_oe && oe_cnt_q != 16'hFFFF) begin
            oe_cnt_d = oe_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_cnt_q   <= '0;
            oe_width_q <= '0;
            oe_valid_q <= 1'b0;
            oe_arm_q   <= 1'b0;
        end else begin
            oe_cnt_q   <= oe_cnt_d;
            oe_width_q <= oe_width_d;
            oe_valid_q <= oe_valid_d;
            oe_arm_q   <= oe_arm_d;
        end
    end

    assign o_oe_width = oe_width_q;
    assign o_oe_valid = oe_valid_q;
`else
    logic oe_unused;
    assign oe_unused = s_oe ^ oe_rise;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Self-checking bench for hub75_capture: table-driven lines against a pixel-level
// reference model, plus directed overrun, reset-mid-drain and OE-width sequences.
module tb_hub75_capture;
    localparam int COLS = 64;
    localparam int RB   = 4;
    localparam int CB   = 6;
    localparam int SS   = 2;

    logic          i_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_clr_err = 1'b0;
    logic          o_wr_en;
    logic [RB+CB-1:0] o_wr_addr;
    logic [5:0]    o_wr_data;
    logic          o_line_done, o_busy, o_len_err, o_overrun;
    logic [15:0]   o_line_cnt;
`ifdef HUB75_OE_MEASURE_EN
    logic [15:0]   o_oe_width;
    logic          o_oe_valid;
`endif

    hub75_capture_if #(.ROW_BITS(RB)) hub ();

    hub75_capture #(.MATRIX_COLS(COLS), .ROW_BITS(RB), .COL_BITS(CB), .SYNC_STAGES(SS)) dut (
        .i_clk       (i_clk),
        .rst_n       (rst_n),
        .hub         (hub),
        .i_clr_err   (i_clr_err),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_line_done (o_line_done),
        .o_busy      (o_busy),
        .o_len_err   (o_len_err),
        .o_overrun   (o_overrun),
`ifdef HUB75_OE_MEASURE_EN
        .o_oe_width  (o_oe_width),
        .o_oe_valid  (o_oe_valid),
`endif
        .o_line_cnt  (o_line_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Write monitor, sampled on the falling edge
    logic [15:0] wq[$];
    int   ld_cnt = 0;
    int   ld_bad = 0;
    logic last_was_end = 1'b0;
    int   oe_pulses = 0;
    int   oe_last = 0;

    always @(negedge i_clk) begin
        if (o_line_done) begin
            ld_cnt++;
            if (!last_was_end) ld_bad++;
        end
        last_was_end = o_wr_en && (o_wr_addr[CB-1:0] == 6'd63);
        if (o_wr_en) wq.push_back({o_wr_addr, o_wr_data});
`ifdef HUB75_OE_MEASURE_EN
        if (o_oe_valid) begin
            oe_pulses++;
            oe_last = int'(o_oe_width);
        end
`endif
    end

    // Reference model: what the panel has been sent, per column, since the last latch
    logic [5:0] shift_img[COLS];
    logic [5:0] exp_line[COLS];
    int cur_col = 0;
    int exp_row = 0;
    int model_lines = 0;

    typedef struct {
        int   npix;
        int   row;
        logic exp_len;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic shift_px(input logic [5:0] px);
        hub.m_color1 = px[2:0];
        hub.m_color2 = px[5:3];
        hub.m_clk = 1'b0;
        tick(2);
        hub.m_clk = 1'b1;
        tick(2);
        hub.m_clk = 1'b0;
        if (cur_col < COLS) shift_img[cur_col] = px;
        cur_col++;
    endtask

    task automatic do_latch(input int row);
        int lat;
        exp_line = shift_img;
        exp_row = row;
        model_lines++;
        cur_col = 0;
        lat = -1;
        hub.m_row_sel = 4'(row);
        hub.m_latch = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (i == 2) hub.m_latch = 1'b0;
            if (o_wr_en) begin
                lat = i;
                break;
            end
        end
        hub.m_latch = 1'b0;
        chk("latency", lat, SS + 2);
    endtask

    task automatic wait_line();
        for (int i = 0; i < 300; i++) begin
            if (wq.size() >= COLS && !o_busy) break;
            tick(1);
        end
        tick(3);
    endtask

    task automatic check_line(input string name);
        int bad = 0;
        for (int k = 0; k < COLS; k++) begin
            if (k >= wq.size()) bad++;
            else if (wq[k] !== {4'(exp_row), 6'(k), exp_line[k]}) bad++;
        end
        chk({name, " write count"}, wq.size(), COLS);
        chk({name, " addr/data"}, bad, 0);
        chk({name, " line_done"}, ld_cnt, 1);
        chk({name, " line_done timing"}, ld_bad, 0);
        chk({name, " line_cnt"}, o_line_cnt, 32'(model_lines & 16'hFFFF));
        wq.delete();
        ld_cnt = 0;
        ld_bad = 0;
    endtask

    task automatic pulse_clr();
        i_clr_err = 1'b1;
        tick(1);
        i_clr_err = 1'b0;
        tick(1);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " wr_en"}, o_wr_en, 0);
        chk({name, " outputs"}, {o_wr_addr, o_wr_data, o_line_done, o_busy, o_len_err, o_overrun}, 0);
        chk({name, " line_cnt"}, o_line_cnt, 0);
    endtask

    initial begin
        hub.m_clk = 1'b0;
        hub.m_oe = 1'b1;
        hub.m_latch = 1'b0;
        hub.m_row_sel = '0;
        hub.m_color1 = '0;
        hub.m_color2 = '0;
        for (int k = 0; k < COLS; k++) shift_img[k] = '0;

        // Reset state
        rst_n = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Directed line: colors = column, row 5 -> addresses 0x140..0x17F
        for (int k = 0; k < COLS; k++) shift_px(6'(k));
        do_latch(5);
        wait_line();
        chk("directed first addr", 32'h140, 32'({4'd5, 6'd0}));
        check_line("directed");
        chk("directed len_err", o_len_err, 0);
        chk("directed overrun", o_overrun, 0);

        // Table of line lengths and rows; the tail entries are randomized
        vecs[0] = '{40, 3, 1'b1};
        vecs[1] = '{70, 9, 1'b1};
        vecs[2] = '{64, 15, 1'b0};
        vecs[3] = '{64, 0, 1'b0};
        vecs[4] = '{1, 7, 1'b1};
        vecs[5] = '{63, 12, 1'b1};
        vecs[6] = '{65, 2, 1'b1};
        vecs[7] = '{0, 11, 1'b1};
        for (int v = 8; v < 13; v++) begin
            vecs[v].npix = int'($urandom_range(58, 70));
            vecs[v].row = int'($urandom_range(0, 15));
            vecs[v].exp_len = (vecs[v].npix != COLS);
        end
        for (int v = 0; v < 13; v++) begin
            for (int p = 0; p < vecs[v].npix; p++) shift_px(6'($urandom_range(0, 63)));
            do_latch(vecs[v].row);
            wait_line();
            check_line($sformatf("vec%0d", v));
            chk($sformatf("vec%0d len_err", v), o_len_err, vecs[v].exp_len);
            chk($sformatf("vec%0d overrun", v), o_overrun, 0);
            pulse_clr();
            chk($sformatf("vec%0d len_err after clear", v), o_len_err, 0);
        end

        // Reset asserted at drain column 20
        for (int k = 0; k < COLS; k++) shift_px(6'($urandom_range(0, 63)));
        do_latch(6);
        for (int i = 0; i < 100; i++) begin
            if (o_wr_en && o_wr_addr[CB-1:0] == 6'd20) break;
            tick(1);
        end
        chk("reached col 20", {o_wr_en, o_wr_addr[CB-1:0]}, {1'b1, 6'd20});
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset mid-drain");
        tick(3);
        check_all_zero("reset held");
        rst_n = 1'b1;
        wq.delete();
        ld_cnt = 0;
        ld_bad = 0;
        model_lines = 0;
        cur_col = 0;
        tick(100);
        chk("no writes after reset", wq.size(), 0);
        chk("no line_done after reset", ld_cnt, 0);

        // Second latch 10 cycles after the first, mid-drain
        for (int k = 0; k < COLS; k++) shift_px(6'($urandom_range(0, 63)));
        exp_line = shift_img;
        exp_row = 10;
        model_lines = 1;
        cur_col = 0;
        hub.m_row_sel = 4'd10;
        hub.m_latch = 1'b1;
        tick(2);
        hub.m_latch = 1'b0;
        tick(8);
        hub.m_row_sel = 4'd3;
        hub.m_latch = 1'b1;
        tick(2);
        hub.m_latch = 1'b0;
        wait_line();
        check_line("overrun");
        chk("overrun flag", o_overrun, 1);
        chk("overrun len_err", o_len_err, 1);
        tick(80);
        chk("dropped line not drained", wq.size(), 0);
        pulse_clr();
        chk("overrun cleared", {o_overrun, o_len_err}, 0);

`ifdef HUB75_OE_MEASURE_EN
        for (int k = 0; k < COLS; k++) shift_px(6'($urandom_range(0, 63)));
        oe_pulses = 0;
        do_latch(1);
        tick(5);
        hub.m_oe = 1'b0;
        tick(256);
        hub.m_oe = 1'b1;
        tick(20);
        chk("oe_valid pulses", oe_pulses, 1);
        chk("oe_width", oe_last, 256);
        wait_line();
        check_line("oe line");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
